// File: rtl/cpu_bus_master.sv
// CPU-side initiator for the 4-bit multiplexed ROM/IO bus: sequences the
// 8-subcycle instruction cycle, fetches OPR/OPA and runs X2 transfers.
module cpu_bus_master #(
    parameter logic [3:0]  IO_OPR     = 4'hE,
    parameter logic [11:0] RESET_ADDR = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [3:0]  data,
    output logic        sync,
    output logic        cmd,
    output logic [2:0]  cycle,
    input  logic [11:0] fetch_addr,
    output logic        fetch_ack,
    output logic [3:0]  inst_opr,
    output logic [3:0]  inst_opa,
    output logic        inst_valid,
    input  logic        x2_src,
    input  logic        x2_drive,
    input  logic        x2_read,
    input  logic [3:0]  x2_data,
    output logic [3:0]  io_rd_data,
    output logic        io_rd_valid
);

    localparam logic [2:0] SC_A1 = 3'd0;
    localparam logic [2:0] SC_A2 = 3'd1;
    localparam logic [2:0] SC_A3 = 3'd2;
    localparam logic [2:0] SC_M1 = 3'd3;
    localparam logic [2:0] SC_M2 = 3'd4;
    localparam logic [2:0] SC_X1 = 3'd5;
    localparam logic [2:0] SC_X2 = 3'd6;
    localparam logic [2:0] SC_X3 = 3'd7;

    logic [2:0]  cycle_q, cycle_d;
    logic [11:0] addr_q;
    logic [3:0]  opr_q, opa_q;
    logic        ival_q;
    logic        src_q, drv_q, rd_q;
    logic [3:0]  x2d_q;
    logic        cmd_q, cmd_d;
    logic        sync_q, ack_q;
    logic [3:0]  rdd_q;
    logic        rdv_q;

    logic        drive_en_c;
    logic [3:0]  drive_val_c;

    // Bus drive: address nibbles in A1..A3, optional X2 nibble; released in reset.
    always_comb begin
        drive_en_c  = 1'b0;
        drive_val_c = 4'h0;
        if (!reset) begin
            case (cycle_q)
                SC_A1: begin drive_en_c = 1'b1; drive_val_c = addr_q[3:0];  end
                SC_A2: begin drive_en_c = 1'b1; drive_val_c = addr_q[7:4];  end
                SC_A3: begin drive_en_c = 1'b1; drive_val_c = addr_q[11:8]; end
                SC_X2: begin drive_en_c = drv_q; drive_val_c = x2d_q;       end
                default: ;
            endcase
        end
    end

    assign data = drive_en_c ? drive_val_c : 4'bzzzz;

    // cmd for the subcycle being entered; M2 uses the OPR being captured now.
    always_comb begin
        cycle_d = cycle_q + 3'd1;
        cmd_d   = 1'b1;
        case (cycle_q)
            SC_M1:   cmd_d = (data != IO_OPR);
            SC_X1:   cmd_d = ~x2_src;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= SC_A1;
            addr_q  <= RESET_ADDR;
            opr_q   <= 4'h0;
            opa_q   <= 4'h0;
            ival_q  <= 1'b0;
            src_q   <= 1'b0;
            drv_q   <= 1'b0;
            rd_q    <= 1'b0;
            x2d_q   <= 4'h0;
            cmd_q   <= 1'b1;
            sync_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdd_q   <= 4'h0;
            rdv_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            cmd_q   <= cmd_d;
            sync_q  <= (cycle_q == SC_X2);
            ack_q   <= (cycle_q == SC_X2);
            ival_q  <= (cycle_q == SC_M2);
            rdv_q   <= (cycle_q == SC_X2) && rd_q;
            if (cycle_q == SC_X3) addr_q <= fetch_addr;
            if (cycle_q == SC_M1) opr_q <= data;
            if (cycle_q == SC_M2) opa_q <= data;
            if (cycle_q == SC_X1) begin
                src_q <= x2_src;
                drv_q <= x2_drive;
                rd_q  <= x2_read;
                x2d_q <= x2_data;
            end
            if ((cycle_q == SC_X2) && rd_q) rdd_q <= data;
        end
    end

    assign cycle       = cycle_q;
    assign cmd         = cmd_q;
    assign sync        = sync_q;
    assign fetch_ack   = ack_q;
    assign inst_opr    = opr_q;
    assign inst_opa    = opa_q;
    assign inst_valid  = ival_q;
    assign io_rd_data  = rdd_q;
    assign io_rd_valid = rdv_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: ROM responder model plus a per-subcycle
// expectation scoreboard filled when each instruction cycle is stimulated.
module tb_cpu_bus_master;

    localparam logic [3:0] CHIP_ID = 4'h0;

    logic        clock = 1'b0;
    logic        reset;
    wire  [3:0]  data;
    logic        sync, cmd, fetch_ack, inst_valid, io_rd_valid;
    logic [2:0]  cycle;
    logic [11:0] fetch_addr;
    logic [3:0]  inst_opr, inst_opa, io_rd_data;
    logic        x2_src, x2_drive, x2_read;
    logic [3:0]  x2_data;

    always #5 clock = ~clock;

    cpu_bus_master dut (
        .clock(clock), .reset(reset), .data(data), .sync(sync), .cmd(cmd),
        .cycle(cycle), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .inst_opr(inst_opr), .inst_opa(inst_opa), .inst_valid(inst_valid),
        .x2_src(x2_src), .x2_drive(x2_drive), .x2_read(x2_read),
        .x2_data(x2_data), .io_rd_data(io_rd_data), .io_rd_valid(io_rd_valid)
    );

    // ROM responder: own subcycle counter, drives M1/M2, WRR writes its port.
    logic [7:0]  rom [0:4095];
    logic [2:0]  r_cyc;
    logic [11:0] r_addr;
    logic        r_wrr, r_sel;
    logic [3:0]  r_port;

    always @(posedge clock) begin
        if (reset) begin
            r_cyc  <= 3'd0;
            r_wrr  <= 1'b0;
            r_sel  <= 1'b1;
            r_port <= 4'h0;
        end else begin
            r_cyc <= r_cyc + 3'd1;
            case (r_cyc)
                3'd0: r_addr[3:0]  <= data;
                3'd1: r_addr[7:4]  <= data;
                3'd2: r_addr[11:8] <= data;
                3'd4: r_wrr <= !cmd && (rom[r_addr] == 8'hE2);
                3'd6: begin
                    if (!cmd) r_sel <= (data == CHIP_ID);
                    else if (r_wrr && r_sel) r_port <= data;
                end
                3'd7: r_wrr <= 1'b0;
                default: ;
            endcase
        end
    end

    logic       rom_oe;
    logic [7:0] rom_byte;
    assign rom_byte = rom[r_addr];
    assign rom_oe   = !reset && ((r_cyc == 3'd3) || (r_cyc == 3'd4));
    assign data     = rom_oe ? ((r_cyc == 3'd3) ? rom_byte[7:4] : rom_byte[3:0]) : 4'bzzzz;

    // Other bus agent: idle pattern in X1/X3, optional X2 nibble, fixed pattern in reset.
    logic       ext6_en;
    logic [3:0] ext6_val;
    logic       ext_oe;
    logic [3:0] ext_val;
    assign ext_oe  = reset || (r_cyc == 3'd5) || (r_cyc == 3'd7) || ((r_cyc == 3'd6) && ext6_en);
    assign ext_val = reset ? 4'h5 : ((r_cyc == 3'd6) ? ext6_val : 4'h0);
    assign data    = ext_oe ? ext_val : 4'bzzzz;

    typedef struct {
        logic [2:0] cyc;
        logic [3:0] dat;
        logic       cmd;
        logic       sync;
        logic       ack;
        logic       ival;
        logic [3:0] opr;
        logic [3:0] opa;
        logic [3:0] rdd;
        logic       rdv;
        logic [3:0] port;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ic = 0;
    logic [3:0] m_opr = 4'h0, m_opa = 4'h0, m_rdd = 4'h0, m_port = 4'h0;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_step(input int s);
        exp_t e;
        string p;
        p = $sformatf("ic%0d.s%0d", ic, s);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", p);
            return;
        end
        e = sb.pop_front();
        check({p, ".cycle"},   12'(cycle),       12'(e.cyc));
        check({p, ".data"},    12'(data),        12'(e.dat));
        check({p, ".cmd"},     12'(cmd),         12'(e.cmd));
        check({p, ".sync"},    12'(sync),        12'(e.sync));
        check({p, ".ack"},     12'(fetch_ack),   12'(e.ack));
        check({p, ".ivalid"},  12'(inst_valid),  12'(e.ival));
        check({p, ".opr"},     12'(inst_opr),    12'(e.opr));
        check({p, ".opa"},     12'(inst_opa),    12'(e.opa));
        check({p, ".rd_data"}, 12'(io_rd_data),  12'(e.rdd));
        check({p, ".rd_valid"},12'(io_rd_valid), 12'(e.rdv));
        check({p, ".rom_port"},12'(r_port),      12'(e.port));
    endtask

    // One instruction cycle; entered and left at subcycle 0, just after a falling edge.
    task automatic run_ic(input logic [11:0] addr, input logic [11:0] nxt,
                          input logic src, input logic drv, input logic rd,
                          input logic [3:0] x2d, input logic [3:0] e6v,
                          input logic [3:0] port_new);
        logic [7:0] b;
        logic [3:0] bus6;
        exp_t e;
        b    = rom[addr];
        bus6 = drv ? x2d : e6v;
        for (int s = 0; s < 8; s++) begin
            e.cyc  = 3'(s);
            case (s)
                0: e.dat = addr[3:0];
                1: e.dat = addr[7:4];
                2: e.dat = addr[11:8];
                3: e.dat = b[7:4];
                4: e.dat = b[3:0];
                6: e.dat = bus6;
                default: e.dat = 4'h0;
            endcase
            e.cmd  = (s == 4) ? (b[7:4] != 4'hE) : ((s == 6) ? !src : 1'b1);
            e.sync = (s == 7);
            e.ack  = (s == 7);
            e.ival = (s == 5);
            e.opr  = (s >= 4) ? b[7:4] : m_opr;
            e.opa  = (s >= 5) ? b[3:0] : m_opa;
            e.rdd  = ((s == 7) && rd) ? bus6 : m_rdd;
            e.rdv  = (s == 7) && rd;
            e.port = (s == 7) ? port_new : m_port;
            sb.push_back(e);
        end
        m_opr  = b[7:4];
        m_opa  = b[3:0];
        if (rd) m_rdd = bus6;
        m_port = port_new;
        for (int s = 0; s < 8; s++) begin
            #1;
            compare_step(s);
            if (s == 3) fetch_addr = nxt;
            if (s == 5) begin
                x2_src   = src;
                x2_drive = drv;
                x2_read  = rd;
                x2_data  = x2d;
                ext6_en  = !drv;
                ext6_val = e6v;
            end
            if (s == 6) begin
                x2_src   = !src;
                x2_drive = !drv;
                x2_read  = !rd;
                x2_data  = ~x2d;
            end
            @(negedge clock);
        end
        ic++;
    endtask

    task automatic check_reset_state(input string p);
        check({p, ".cycle"},    12'(cycle),       12'h0);
        check({p, ".cmd"},      12'(cmd),         12'h1);
        check({p, ".sync"},     12'(sync),        12'h0);
        check({p, ".ack"},      12'(fetch_ack),   12'h0);
        check({p, ".ivalid"},   12'(inst_valid),  12'h0);
        check({p, ".opr"},      12'(inst_opr),    12'h0);
        check({p, ".opa"},      12'(inst_opa),    12'h0);
        check({p, ".rd_data"},  12'(io_rd_data),  12'h0);
        check({p, ".rd_valid"}, 12'(io_rd_valid), 12'h0);
        check({p, ".bus"},      12'(data),        12'h5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'hD5;
        rom[12'h3A7] = 8'h80;
        rom[12'h100] = 8'hE2;
        rom[12'h101] = 8'hE2;
        rom[12'h102] = 8'hE2;
        rom[12'h200] = 8'h21;
        rom[12'h201] = 8'h21;
        rom[12'h300] = 8'hE9;
        rom[12'h301] = 8'h4C;
        rom[12'h302] = 8'hE0;
        rom[12'h555] = 8'hE0;

        reset      = 1'b1;
        fetch_addr = 12'h000;
        x2_src     = 1'b0;
        x2_drive   = 1'b0;
        x2_read    = 1'b0;
        x2_data    = 4'h0;
        ext6_en    = 1'b1;
        ext6_val   = 4'h0;

        repeat (3) @(negedge clock);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        //     addr     next     src   drv   rd    x2d   e6v   port
        run_ic(12'h000, 12'h3A7, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        run_ic(12'h3A7, 12'h100, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        run_ic(12'h100, 12'h200, 1'b0, 1'b1, 1'b0, 4'h9, 4'h0, 4'h9);
        run_ic(12'h200, 12'h101, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h9);
        run_ic(12'h101, 12'h201, 1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 4'h4);
        run_ic(12'h201, 12'h102, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 4'h4);
        run_ic(12'h102, 12'h300, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'h4);
        run_ic(12'h300, 12'h301, 1'b0, 1'b0, 1'b1, 4'h0, 4'h6, 4'h4);
        run_ic(12'h301, 12'h302, 1'b0, 1'b0, 1'b0, 4'h0, 4'hB, 4'h4);
        run_ic(12'h302, 12'h555, 1'b0, 1'b1, 1'b1, 4'hA, 4'h0, 4'h4);

        // Reset raised in the middle of M2 of an I/O instruction, held two clocks.
        repeat (4) @(negedge clock);
        #1;
        check("mid.cycle", 12'(cycle),    12'h4);
        check("mid.cmd",   12'(cmd),      12'h0);
        check("mid.opr",   12'(inst_opr), 12'hE);
        reset = 1'b1;
        #1;
        check("mid.bus", 12'(data), 12'h5);
        @(negedge clock);
        #1;
        check_reset_state("rst1");
        @(negedge clock);
        #1;
        check_reset_state("rst2");
        reset  = 1'b0;
        m_opr  = 4'h0;
        m_opa  = 4'h0;
        m_rdd  = 4'h0;
        m_port = 4'h0;
        run_ic(12'h000, 12'h3A7, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- CPU-side initiator for the 4-bit multiplexed ROM/IO bus; the ROM chip is the responder.
- Runs the 8-subcycle instruction cycle and drives the 12-bit fetch address as nibbles in subcycles 0–2.
- Captures the OPR and OPA nibbles in subcycles 3–4 and presents them to the core.
- Drives cmd for I/O instructions and SRC, and drives or samples the X2 data nibble for I/O transfers.

Parameters:
IO_OPR, 4'hE, OPR value marking the I/O group; cmd is asserted in M2 when the captured OPR matches.
RESET_ADDR, 12'h000, fetch address used for the first instruction cycle after reset.

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
data  inout  4  shared multiplexed bus
sync  out  1  high during subcycle 7, marks the end of an instruction cycle
cmd  out  1  active-low command/select strobe
cycle  out  3  current subcycle, 0..7
fetch_addr  in  12  address of the next instruction, sampled at the end of subcycle 7
fetch_ack  out  1  one-clock pulse in subcycle 7, when fetch_addr is consumed
inst_opr  out  4  captured upper instruction nibble
inst_opa  out  4  captured lower instruction nibble
inst_valid  out  1  one-clock pulse in subcycle 5, when the OPR/OPA pair is new
x2_src  in  1  request cmd low in X2 (SRC chip select)
x2_drive  in  1  request to drive x2_data onto the bus in X2
x2_read  in  1  request to sample the bus in X2
x2_data  in  4  nibble to drive in X2
io_rd_data  out  4  nibble sampled in X2
io_rd_valid  out  1  one-clock pulse in subcycle 7 after a requested X2 read

Behaviour:
- Subcycle counter `cycle`
  - Reset value 0; increments by 1 every clock and wraps 7→0.
  - Lockstep with responders, which also reset to subcycle 0.
  - Naming: 0–2 are A1..A3, 3–4 are M1..M2, 5–7 are X1..X3.
- Address register
  - Reset to RESET_ADDR.
  - Loads fetch_addr on the clock edge ending subcycle 7; holds otherwise.
  - fetch_ack is high exactly while cycle==7.
- Data bus drive
  - Combinational from cycle and registered state.
  - cycle 0: addr[3:0]; cycle 1: addr[7:4]; cycle 2: addr[11:8].
  - cycle 6 with latched x2_drive=1: latched x2_data.
  - High-Z at all other times, including cycles 3 and 4 (the responder drives in M1/M2) and the whole time reset is high.
  - Driving in cycles 3 or 4 is a contention violation.
- Instruction capture
  - inst_opr <= data on the edge ending cycle 3.
  - inst_opa <= data on the edge ending cycle 4.
  - inst_valid is registered: high only while cycle==5.
  - Reset values: inst_opr=0, inst_opa=0, inst_valid=0.
- X2 request latching
  - x2_src, x2_drive, x2_read and x2_data are sampled into registers on the edge ending cycle 5.
  - Core changes after that edge have no effect until the next instruction cycle.
  - All four latches reset to 0.
- cmd (reset value 1, idle high)
  - Low during cycle 4 iff inst_opr==IO_OPR; this uses the value captured at the end of cycle 3, i.e. the current instruction.
  - Low during cycle 6 iff latched x2_src=1.
  - High during cycle 7 unconditionally, so responders clear their active flags.
  - Must be glitch-free: drive from a register, updated on the edge entering the subcycle.
- sync: registered, high only while cycle==7; reset value 0.
- X2 read
  - If latched x2_read=1, io_rd_data <= data on the edge ending cycle 6, and io_rd_valid is high while cycle==7.
  - Otherwise io_rd_data holds and io_rd_valid stays 0.
  - Reset: io_rd_data=0, io_rd_valid=0.
- Simultaneous x2_drive and x2_read: drive takes effect and io_rd_data captures the master's own driven nibble (allowed, not an error).
- Reset mid-cycle
  - All state returns to reset values on the next edge; the bus goes high-Z immediately while reset is high.
  - After reset deassertion the first address driven is RESET_ADDR in cycle 0.

Test Plan:
- Reset, RESET_ADDR=12'h000, ROM holds 8'hD5 at 0 → data=0,0,0 in cycles 0–2; inst_opr=D, inst_opa=5; inst_valid pulses once in cycle 5; cmd high for the whole cycle.
- fetch_addr=12'h3A7 presented before cycle 7 → fetch_ack in cycle 7; next cycle drives 7,A,3 on data in cycles 0,1,2; data is high-Z in cycles 3–4.
- ROM byte 8'hE2 (WRR) with x2_drive=1, x2_data=9 raised in cycle 5 → cmd low in cycle 4; data=9 in cycle 6; ROM output port becomes 9.
- SRC: x2_src=1, x2_drive=1, x2_data=0 → cmd low only in cycle 6 (high in 4 and 7); ROM selected; next E2 cycle with x2_data=4 updates the ROM port to 4. Repeat with x2_data=3 → ROM not selected, port unchanged.
- x2_read=1, external driver puts 6 on data in cycle 6 → io_rd_data=6, io_rd_valid high only in cycle 7; with x2_read=0, io_rd_data is unchanged.
- Reset asserted in cycle 4 for 2 clocks → data high-Z, cmd=1, sync=0, cycle=0, inst_valid=0; refetch starts from RESET_ADDR.
